hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding logic in the ID/EX boundary.
- Decides per cycle whether PC and IF/ID advance, stall or flush, and whether ID/EX receives a bubble.
- Covers hazards forwarding cannot resolve: load-use, taken branches resolved in EX, and the multi-cycle mult/div unit occupying HI/LO.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MD_LATENCY, 32, cycles the mult/div unit is busy after issue (minimum 2)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
IFIDRs  input  5  Rs field of the instruction in ID
IFIDRt  input  5  Rt field of the instruction in ID
IFIDUsesRt  input  1  ID instruction reads Rt as a source
IDMulDiv  input  1  ID instruction is mult/multu/div/divu
IDUsesHiLo  input  1  ID instruction is mfhi/mflo
IDEXMemRead  input  1  EX instruction is a load
IDEXRt  input  5  destination of the load in EX
EXBranchTaken  input  1  branch/jump in EX resolved taken this cycle
PCWrite  output  1  PC may update
IFIDWrite  output  1  IF/ID register may load
IFIDFlush  output  1  IF/ID loads a nop
IDEXBubble  output  1  ID/EX loads a nop (control bits zeroed)
mdBusy  output  1  mult/div unit occupied
stallCycles  output  CNT_W  saturating count of cycles with PCWrite=0

Behaviour:
- Reset (rst_n low, async):
  - State goes to RUN; md counter and stallCycles go to 0.
  - Outputs forced while low: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, mdBusy=0.
- FSM states: RUN, MD_BUSY. mdBusy=1 exactly in MD_BUSY.
- loadUse (combinational) = IDEXMemRead & (IDEXRt!=0) & ((IDEXRt==IFIDRs) | (IFIDUsesRt & IDEXRt==IFIDRt)).
- mdHaz = (state==MD_BUSY) & (IDMulDiv | IDUsesHiLo).
- Output priority, all combinational, same cycle:
  1. EXBranchTaken: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=1. Overrides any stall; the ID instruction is discarded.
  2. else loadUse | mdHaz: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=1.
  3. else: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- Issue = IDMulDiv & ~EXBranchTaken & ~loadUse & ~mdHaz.
- Transitions:
  - RUN to MD_BUSY on issue; md counter loads MD_LATENCY-1.
  - MD_BUSY: counter decrements each cycle. When counter==1 at a clock edge, the next state is RUN.
  - Result: mdBusy is high for exactly MD_LATENCY-1 cycles after the issue cycle.
  - A branch flush in MD_BUSY does not cancel the busy period, because the mult/div is older than the branch.
- A mult/div or mfhi/mflo stalled by mdHaz issues or proceeds in the first cycle state==RUN, which is the cycle after mdBusy falls.
- Load-use stall lasts exactly one cycle: the next cycle the load is in MEM, IDEXMemRead is normally 0, and forwarding covers the dependency.
- stallCycles increments on every clock with PCWrite=0 and rst_n high. It saturates at all-ones with no wrap.
- Register $0 never causes a load-use stall.
- Counter widths: md counter $clog2(MD_LATENCY+1) bits. No arithmetic beyond decrement and saturating increment.

Decomposition:
- Shared package pipeline_pkg: FSM state encoding (RUN=1'b0, MD_BUSY=1'b1), REG_ZERO=5'd0, nop encoding used with the flush/bubble outputs.
- One natural sub-module, load_use_detector: pure combinational loadUse compare, reusable by a future dual-issue front end.
- FSM, md counter and perf counter stay in the top module.

Test Plan:
- Reset mid-MD_BUSY (counter=10), then release → mdBusy=0, stallCycles=0, state RUN, PCWrite=1 on the first cycle after release with idle inputs.
- Load-use: IDEXMemRead=1, IDEXRt=5'd8, IFIDRs=5'd8 for one cycle → PCWrite=0, IFIDWrite=0, IDEXBubble=1 that cycle. Then IDEXMemRead=0 → free-run; stallCycles=1.
- Load to $0: IDEXMemRead=1, IDEXRt=0, IFIDRs=0 → no stall. IFIDUsesRt=0 with IDEXRt==IFIDRt=5'd9 → no stall.
- Mult/div with MD_LATENCY=4: issue IDMulDiv at cycle 0 → mdBusy high cycles 1-3. mfhi held in ID from cycle 1 → PCWrite=0 cycles 1-3, proceeds at cycle 4; stallCycles=3.
- Branch plus load-use same cycle: EXBranchTaken=1 with loadUse=1 → PCWrite=1, IFIDFlush=1, IDEXBubble=1, stallCycles unchanged.
- Branch flushes an ID mult in RUN → no transition to MD_BUSY. Saturation with CNT_W=4: hold loadUse 20 cycles → stallCycles=15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types: mult/div FSM encoding, register $0 and the
// control bundles driven onto PC, IF/ID and ID/EX.
package pipeline_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  // sll $0,$0,0 -- what IF/ID or ID/EX hold when flushed or bubbled
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0,
                                        ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1,
                                        ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0,
                                        ifid_flush: 1'b0, idex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1,
                                        ifid_flush: 1'b0, idex_bubble: 1'b0};

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard compare between the load in EX and the
// source registers of the instruction in ID.
module load_use_detector
  import pipeline_pkg::*;
(
  input  logic       i_idex_mem_read,
  input  logic [4:0] i_idex_rt,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_ifid_uses_rt,
  output logic       o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_idex_rt == i_ifid_rs);
  assign w_rt_match = i_ifid_uses_rt && (i_idex_rt == i_ifid_rt);

  // $0 is hardwired, so a load targeting it never creates a dependency
  assign o_load_use = i_idex_mem_read && (i_idex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: load-use stalls, branch flushes and mult/div HI/LO
// interlock, plus a saturating count of stalled cycles.
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_ifid_rs,
  input  logic [4:0]       i_ifid_rt,
  input  logic             i_ifid_uses_rt,
  input  logic             i_id_mul_div,
  input  logic             i_id_uses_hilo,
  input  logic             i_idex_mem_read,
  input  logic [4:0]       i_idex_rt,
  input  logic             i_ex_branch_taken,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int unsigned MD_CNT_W = $clog2(MD_LATENCY + 1);
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

  md_state_e           r_state;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic       w_load_use;
  logic       w_md_haz;
  logic       w_issue;
  pipe_ctrl_t w_ctrl;

  load_use_detector u_load_use_detector (
    .i_idex_mem_read (i_idex_mem_read),
    .i_idex_rt       (i_idex_rt),
    .i_ifid_rs       (i_ifid_rs),
    .i_ifid_rt       (i_ifid_rt),
    .i_ifid_uses_rt  (i_ifid_uses_rt),
    .o_load_use      (w_load_use)
  );

  assign w_md_haz = (r_state == MD_BUSY) && (i_id_mul_div || i_id_uses_hilo);
  assign w_issue  = i_id_mul_div && !i_ex_branch_taken && !w_load_use && !w_md_haz;

  // Taken branch wins over any stall: the ID instruction is discarded anyway
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (!rst_n) begin
      w_ctrl = CTRL_RESET;
    end else if (i_ex_branch_taken) begin
      w_ctrl = CTRL_FLUSH;
    end else if (w_load_use || w_md_haz) begin
      w_ctrl = CTRL_STALL;
    end
  end

  // A branch flush while busy leaves the count alone: the mult/div is older
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_issue) begin
            r_state  <= MD_BUSY;
            r_md_cnt <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          r_md_cnt <= r_md_cnt - MD_CNT_W'(1);
          if (r_md_cnt == MD_CNT_W'(1)) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_ctrl.pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_pc_write     = w_ctrl.pc_write;
  assign o_ifid_write   = w_ctrl.ifid_write;
  assign o_ifid_flush   = w_ctrl.ifid_flush;
  assign o_idex_bubble  = w_ctrl.idex_bubble;
  assign o_md_busy      = (r_state == MD_BUSY);
  assign o_stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with MD_LATENCY=4, CNT_W=4.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, id_mul_div, id_uses_hilo, idex_mem_read, ex_branch_taken;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;
  logic [3:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] E_RESET = 4'b0011;
  localparam logic [3:0] E_FLUSH = 4'b1111;
  localparam logic [3:0] E_STALL = 4'b0001;
  localparam logic [3:0] E_RUN   = 4'b1100;

  hazard_stall_controller #(
    .MD_LATENCY (4),
    .CNT_W      (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_ifid_rs         (ifid_rs),
    .i_ifid_rt         (ifid_rt),
    .i_ifid_uses_rt    (ifid_uses_rt),
    .i_id_mul_div      (id_mul_div),
    .i_id_uses_hilo    (id_uses_hilo),
    .i_idex_mem_read   (idex_mem_read),
    .i_idex_rt         (idex_rt),
    .i_ex_branch_taken (ex_branch_taken),
    .o_pc_write        (pc_write),
    .o_ifid_write      (ifid_write),
    .o_ifid_flush      (ifid_flush),
    .o_idex_bubble     (idex_bubble),
    .o_md_busy         (md_busy),
    .o_stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, pc_write, ifid_write, ifid_flush, idex_bubble}, {28'd0, exp});
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
    ifid_uses_rt = 1'b0; id_mul_div = 1'b0; id_uses_hilo = 1'b0;
    idex_mem_read = 1'b0; ex_branch_taken = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    id_mul_div = 1'b1;
    #2;
    chk_ctrl("reset_ctrl", E_RESET);
    chk("reset_busy", {31'd0, md_busy}, 32'd0);
    chk("reset_cnt", {28'd0, stall_cycles}, 32'd0);

    // Issue a mult, stall an mfhi once, then reset in the middle of the busy period
    cyc();
    rst_n = 1'b1;
    #1;
    chk_ctrl("issue_ctrl", E_RUN);
    cyc();
    id_mul_div = 1'b0; id_uses_hilo = 1'b1;
    #1;
    chk("busy_after_issue", {31'd0, md_busy}, 32'd1);
    chk_ctrl("mfhi_busy_stall", E_STALL);
    cyc();
    chk("cnt_before_reset", {28'd0, stall_cycles}, 32'd1);
    idle();
    rst_n = 1'b0;
    #1;
    chk("busy_in_reset", {31'd0, md_busy}, 32'd0);
    chk("cnt_in_reset", {28'd0, stall_cycles}, 32'd0);
    chk_ctrl("ctrl_in_reset", E_RESET);
    cyc();
    rst_n = 1'b1;
    #1;
    chk_ctrl("post_reset_ctrl", E_RUN);
    cyc();
    chk("post_reset_busy", {31'd0, md_busy}, 32'd0);
    chk("post_reset_cnt", {28'd0, stall_cycles}, 32'd0);

    // Load-use on Rs
    idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    #1;
    chk_ctrl("lu_rs_stall", E_STALL);
    cyc();
    idle();
    #1;
    chk_ctrl("lu_release", E_RUN);
    chk("lu_cnt", {28'd0, stall_cycles}, 32'd1);

    // Rt match counts only when the ID instruction reads Rt
    idex_mem_read = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9; ifid_rs = 5'd3;
    #1;
    chk_ctrl("lu_rt_unused", E_RUN);
    ifid_uses_rt = 1'b1;
    #1;
    chk_ctrl("lu_rt_used", E_STALL);
    cyc();
    chk("lu_rt_cnt", {28'd0, stall_cycles}, 32'd2);

    // Load to $0 never stalls
    idle();
    idex_mem_read = 1'b1;
    #1;
    chk_ctrl("lu_zero", E_RUN);
    cyc();
    chk("lu_zero_cnt", {28'd0, stall_cycles}, 32'd2);

    // Clean counter, then mult issue + mfhi held in ID
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cyc();
    id_mul_div = 1'b1;
    #1;
    chk_ctrl("md_issue", E_RUN);
    chk("md_c0_busy", {31'd0, md_busy}, 32'd0);
    cyc();
    id_mul_div = 1'b0; id_uses_hilo = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("md_c%0d_busy", i), {31'd0, md_busy}, 32'd1);
      chk_ctrl($sformatf("md_c%0d_ctrl", i), E_STALL);
      cyc();
    end
    chk("md_c4_busy", {31'd0, md_busy}, 32'd0);
    chk_ctrl("md_c4_ctrl", E_RUN);
    chk("md_cnt", {28'd0, stall_cycles}, 32'd3);

    // Branch overrides a same-cycle load-use
    idle();
    idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ex_branch_taken = 1'b1;
    #1;
    chk_ctrl("br_over_lu", E_FLUSH);
    cyc();
    chk("br_cnt", {28'd0, stall_cycles}, 32'd3);

    // Branch while busy does not cancel the mult/div
    idle();
    id_mul_div = 1'b1;
    cyc();
    id_mul_div = 1'b0; ex_branch_taken = 1'b1;
    #1;
    chk_ctrl("br_in_busy", E_FLUSH);
    cyc();
    ex_branch_taken = 1'b0;
    #1;
    chk("busy_after_br", {31'd0, md_busy}, 32'd1);
    cyc();
    cyc();
    chk("busy_end_br", {31'd0, md_busy}, 32'd0);

    // Branch flushes an ID mult in RUN: no issue
    id_mul_div = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk_ctrl("br_kill_mult", E_FLUSH);
    cyc();
    idle();
    #1;
    chk("no_busy_killed", {31'd0, md_busy}, 32'd0);
    chk("cnt_before_sat", {28'd0, stall_cycles}, 32'd3);

    // Saturation: 3 + 20 stalled cycles clamps at 15
    idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    repeat (11) cyc();
    chk("sat_14", {28'd0, stall_cycles}, 32'd14);
    repeat (9) cyc();
    chk("sat_15", {28'd0, stall_cycles}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
